// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select encodings, driver FSM states and default widths.
package alu_pkg;
    localparam int DATA_W_DEF = 4;
    localparam int RES_W_DEF  = DATA_W_DEF + 1;
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_GT   = 3'b111;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command initiator for the combinational ALU, returning registered results.
// Define ALU_DIVZERO_CHECK_EN to flag and zero div/mod results when the divisor is 0.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = DATA_W + 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [RES_W-1:0]  alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic [2:0]        rsp_sel,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);
    state_t state, state_nxt;
    logic   cmd_fire;
    logic   div_zero;

`ifdef ALU_DIVZERO_CHECK_EN
    assign div_zero = (alu_sel == OP_DIV || alu_sel == OP_MOD) && alu_b == '0;
`else
    assign div_zero = 1'b0;
`endif

    // rsp_ready feeds cmd_ready directly so a new command can follow a consumed response
    always_comb begin
        cmd_ready = rst_n && (state == IDLE || (state == RESP && rsp_ready));
        cmd_fire  = cmd_valid && cmd_ready;
        rsp_valid = state == RESP;
        state_nxt = state == EXEC ? RESP :
                    cmd_fire ? EXEC :
                    (state == RESP && rsp_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            rsp_data <= '0;
            rsp_sel  <= '0;
            rsp_err  <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_sel;
            end
            if (state == EXEC) begin
                rsp_data <= div_zero ? '0 : alu_out;
                rsp_sel  <= alu_sel;
                rsp_err  <= div_zero;
            end
            if (rsp_valid && rsp_ready && op_count != '1)
                op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed and random checks of alu_cmd_driver against a transaction-level model.
// Expectations follow ALU_DIVZERO_CHECK_EN when the bench is built with it.
module tb_alu_cmd_driver;
    import alu_pkg::*;
    localparam int DW = 4;
    localparam int RW = 5;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_sel = '0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [RW-1:0] alu_out;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [RW-1:0] rsp_data;
    logic [2:0]    rsp_sel;
    logic          rsp_err;
    logic [CW-1:0] op_count;

    int n_checks = 0;
    int n_fail = 0;

    alu_cmd_driver #(.DATA_W(DW), .RES_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_sel(rsp_sel), .rsp_err(rsp_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // stand-in for the team ALU; the driver only forwards its result
    function automatic logic [RW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] s);
        case (s)
            OP_PASS: return {1'b0, a};
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_DIV:  return b == 0 ? 5'h1f : {1'b0, a / b};
            OP_MOD:  return b == 0 ? 5'h1f : {1'b0, a % b};
            OP_SHL:  return {1'b0, a} << b[1:0];
            OP_SHR:  return {1'b0, a >> b};
            default: return {4'b0, a > b};
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_a, alu_b, alu_sel);

    function automatic bit divz(input logic [2:0] s, input logic [DW-1:0] b);
`ifdef ALU_DIVZERO_CHECK_EN
        return (s == OP_DIV || s == OP_MOD) && b == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] s);
        cmd_valid = v;
        cmd_a = a;
        cmd_b = b;
        cmd_sel = s;
    endtask

    // transaction model: one command in execution, one held response, saturating count
    bit            m_exec, m_resp, m_err, exp_rdy, cmd_hs, rsp_hs;
    logic [DW-1:0] m_a, m_b;
    logic [2:0]    m_sel, m_rsel;
    logic [RW-1:0] m_data;
    int            m_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_exec = 0; m_resp = 0; m_err = 0; m_cnt = 0;
            m_a = '0; m_b = '0; m_sel = '0; m_data = '0; m_rsel = '0;
            chk("reset_cmd_ready", cmd_ready, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_op_count", op_count, 0);
        end else begin
            exp_rdy = !m_exec && (!m_resp || rsp_ready);
            chk("rsp_valid", rsp_valid, m_resp);
            if (m_resp) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_sel", rsp_sel, m_rsel);
                chk("rsp_err", rsp_err, m_err);
            end
            chk("op_count", op_count, m_cnt);
            chk("cmd_ready", cmd_ready, exp_rdy);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_sel", alu_sel, m_sel);
            rsp_hs = m_resp && rsp_ready;
            cmd_hs = cmd_valid && exp_rdy;
            if (rsp_hs) begin
                m_resp = 0;
                if (m_cnt < CMAX) m_cnt++;
            end
            if (m_exec) begin
                m_err = divz(m_sel, m_b);
                m_data = m_err ? '0 : alu_fn(m_a, m_b, m_sel);
                m_rsel = m_sel;
                m_resp = 1;
                m_exec = 0;
            end
            if (cmd_hs) begin
                m_exec = 1;
                m_a = cmd_a;
                m_b = cmd_b;
                m_sel = cmd_sel;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step;
        rst_n = 1'b1;
        step;
        // basic add: operands visible after accept, result two edges later
        set_cmd(1, 4'd9, 4'd5, OP_ADD);
        rsp_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t1_alu_a", alu_a, 9);
        chk("t1_alu_b", alu_b, 5);
        step;
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_data", rsp_data, 14);
        chk("t1_rsp_sel", rsp_sel, 1);
        step;
        @(negedge clk);
        chk("t1_op_count", op_count, 1);
        // divide by zero
        set_cmd(1, 4'd7, 4'd0, OP_DIV);
        step;
        cmd_valid = 1'b0;
        step;
        @(negedge clk);
`ifdef ALU_DIVZERO_CHECK_EN
        chk("t2_rsp_err", rsp_err, 1);
        chk("t2_rsp_data", rsp_data, 0);
`else
        chk("t2_rsp_err", rsp_err, 0);
        chk("t2_rsp_data", rsp_data, 31);
`endif
        step;
        // back-pressure: response held stable
        rsp_ready = 1'b0;
        set_cmd(1, 4'd3, 4'd5, OP_SUB);
        step;
        cmd_valid = 1'b0;
        step;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_rsp_valid", rsp_valid, 1);
            chk("t3_rsp_data", rsp_data, 5'b11110);
            chk("t3_cmd_ready", cmd_ready, 0);
            chk("t3_op_count", op_count, 2);
            step;
        end
        rsp_ready = 1'b1;
        step;
        // back-to-back commands
        for (int i = 0; i < 4; i++) begin
            set_cmd(1, 4'(i + 1), 4'(i + 2), OP_ADD);
            step;
            step;
        end
        cmd_valid = 1'b0;
        step;
        @(negedge clk);
        chk("t4_op_count", op_count, 7);
        // reset while a command executes
        set_cmd(1, 4'd1, 4'd2, OP_ADD);
        step;
        cmd_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_alu_a", alu_a, 0);
        chk("t5_cmd_ready", cmd_ready, 0);
        chk("t5_op_count", op_count, 0);
        repeat (2) step;
        rst_n = 1'b1;
        step;
        @(negedge clk);
        chk("t5_no_rsp", rsp_valid, 0);
        set_cmd(1, 4'd2, 4'd3, OP_ADD);
        step;
        cmd_valid = 1'b0;
        step;
        @(negedge clk);
        chk("t5_rsp_data", rsp_data, 5);
        step;
        @(negedge clk);
        chk("t5_op_count_after", op_count, 1);
        // random traffic, long enough to saturate the counter
        for (int i = 0; i < 1200; i++) begin
            set_cmd($urandom_range(0, 2) != 0, 4'($urandom), 4'($urandom_range(0, 15)), 3'($urandom));
            rsp_ready = $urandom_range(0, 3) != 0;
            step;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) step;
        @(negedge clk);
        chk("sat_op_count", op_count, CMAX);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
